// File: rtl/serial_lfsr_engine_pkg.sv
// Shared constants and types for the serial LFSR engine and its step function.
package serial_lfsr_engine_pkg;

  typedef enum logic [1:0] {
    MODE_PRBS  = 2'd0,
    MODE_CRC   = 2'd1,
    MODE_CHECK = 2'd2
  } mode_e;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_DONE = 2'd2;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_SEED = 2'd1;
  localparam logic [1:0] REG_POLY = 2'd2;
  localparam logic [1:0] REG_LEN  = 2'd3;

  localparam int unsigned CTRL_MODE_LSB = 0;
  localparam int unsigned CTRL_START    = 2;
  localparam int unsigned CTRL_ABORT    = 3;

  // Reserved encoding 3 falls back to PRBS.
  function automatic mode_e decode_mode(input logic [1:0] raw);
    return (raw == 2'd3) ? MODE_PRBS : mode_e'(raw);
  endfunction

endpackage

// File: rtl/serial_lfsr_engine_lfsr_galois_step.sv
// One-bit Galois LFSR advance; in CRC mode the input bit is folded into the feedback.
module lfsr_galois_step #(
  parameter int unsigned W = 6
) (
  input  logic [W-1:0] lfsr,
  input  logic [W-1:0] poly,
  input  logic         din,
  input  logic         crc_en,
  output logic [W-1:0] next,
  output logic         fb
);

  always_comb begin
    fb   = lfsr[W-1] ^ (crc_en & din);
    next = {lfsr[W-2:0], 1'b0} ^ (fb ? poly : '0);
  end

endmodule

// File: rtl/serial_lfsr_engine.sv
// Bus-programmable LFSR engine: PRBS generation, CRC accumulation and sequence checking.
module serial_lfsr_engine
  import serial_lfsr_engine_pkg::*;
#(
  parameter int unsigned W        = 6,
  parameter logic [W-1:0] POLY_DEF = 6'h03,
  parameter logic [W-1:0] SEED_DEF = 6'h01,
  parameter int unsigned LEN_W    = 8,
  parameter int unsigned ERR_W    = 8,
  parameter int unsigned DW       = (W > LEN_W) ? W : LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic             wr,
  input  logic             rd,
  input  logic [1:0]       addr,
  input  logic [DW-1:0]    wdata,
  output logic [DW-1:0]    rdata,
  input  logic             step,
  input  logic             din,
  output logic             dout,
  output logic             busy,
  output logic             done,
  output logic [ERR_W-1:0] err_cnt
);

  state_t           state_q, state_d;
  mode_e            mode_q, mode_d, new_mode;
  logic [W-1:0]     lfsr_q, lfsr_d, seed_q, seed_d, poly_q, poly_d;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic [W-1:0]     lfsr_next;
  logic             fb;
  logic             bus_wr, ctrl_wr;

  lfsr_galois_step #(
    .W(W)
  ) u_step (
    .lfsr   (lfsr_q),
    .poly   (poly_q),
    .din    (din),
    .crc_en (mode_q == MODE_CRC),
    .next   (lfsr_next),
    .fb     (fb)
  );

  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign dout     = lfsr_q[W-1];
  assign rdata    = rdata_q;
  assign err_cnt  = err_q;
  assign bus_wr   = sel & wr;
  assign ctrl_wr  = bus_wr & (addr == REG_CTRL);
  assign new_mode = decode_mode(wdata[CTRL_MODE_LSB+1:CTRL_MODE_LSB]);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    lfsr_d  = lfsr_q;
    seed_d  = seed_q;
    poly_d  = poly_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;

    if (sel && rd) begin
      rdata_d = '0;
      unique case (addr)
        REG_CTRL: rdata_d[3:0]       = {busy, done, mode_q};
        REG_SEED: rdata_d[W-1:0]     = lfsr_q;
        REG_POLY: rdata_d[W-1:0]     = poly_q;
        REG_LEN:  rdata_d[LEN_W-1:0] = cnt_q;
      endcase
    end

    if (state_q == S_RUN) begin
      if (ctrl_wr && wdata[CTRL_ABORT]) begin
        state_d = S_IDLE;
      end else if (step) begin
        lfsr_d = lfsr_next;
        cnt_d  = cnt_q - LEN_W'(1);
        // Outside CRC mode fb is the pre-step MSB, i.e. the expected bit.
        if (mode_q == MODE_CHECK && (din ^ fb) && err_q != '1) begin
          err_d = err_q + ERR_W'(1);
        end
        if (cnt_q == LEN_W'(1)) state_d = S_DONE;
      end
    end else if (bus_wr) begin
      unique case (addr)
        REG_CTRL: begin
          if (wdata[CTRL_ABORT]) begin
            state_d = S_IDLE;
          end else begin
            mode_d = new_mode;
            if (wdata[CTRL_START]) begin
              // An all-zero seed would lock up PRBS/CHECK sequences.
              lfsr_d  = (seed_q == '0 && new_mode != MODE_CRC) ? W'(1) : seed_q;
              cnt_d   = len_q;
              err_d   = '0;
              state_d = (len_q == '0) ? S_DONE : S_RUN;
            end
          end
        end
        REG_SEED: seed_d = wdata[W-1:0];
        REG_POLY: poly_d = wdata[W-1:0];
        REG_LEN:  len_d  = wdata[LEN_W-1:0];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_PRBS;
      lfsr_q  <= SEED_DEF;
      seed_q  <= SEED_DEF;
      poly_q  <= POLY_DEF;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      lfsr_q  <= lfsr_d;
      seed_q  <= seed_d;
      poly_q  <= poly_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_serial_lfsr_engine.sv
// Directed bench for serial_lfsr_engine with a read-data scoreboard.
module tb_serial_lfsr_engine;

  logic       clk = 1'b0;
  logic       rst, sel, wr, rd, step, din;
  logic [1:0] addr;
  logic [7:0] wdata, rdata, rdata2;
  logic       dout, busy, done, dout2, busy2, done2;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt2;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  serial_lfsr_engine dut (
    .clk(clk), .rst(rst), .sel(sel), .wr(wr), .rd(rd), .addr(addr), .wdata(wdata),
    .rdata(rdata), .step(step), .din(din), .dout(dout), .busy(busy), .done(done),
    .err_cnt(err_cnt)
  );

  serial_lfsr_engine #(.ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .sel(sel), .wr(wr), .rd(rd), .addr(addr), .wdata(wdata),
    .rdata(rdata2), .step(step), .din(din), .dout(dout2), .busy(busy2), .done(done2),
    .err_cnt(err_cnt2)
  );

  function automatic logic [5:0] mstep(input logic [5:0] l, input logic [5:0] p,
                                       input logic d, input logic crc);
    logic fb;
    fb = l[5] ^ (crc & d);
    return {l[4:0], 1'b0} ^ (fb ? p : 6'h00);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    sel = 1'b1; wr = 1'b1; addr = a; wdata = d;
    tick();
    sel = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    sel = 1'b1; rd = 1'b1; addr = a;
    tick();
    sel = 1'b0; rd = 1'b0;
    check(tag_q.pop_front(), 32'(rdata), exp_q.pop_front());
  endtask

  task automatic do_step(input logic d);
    step = 1'b1; din = d;
    tick();
    step = 1'b0; din = 1'b0;
  endtask

  task automatic run_check(input logic [19:0] inv);
    logic [5:0] m;
    m = 6'h01;
    bus_write(2'd1, 8'h01);
    bus_write(2'd3, 8'd20);
    bus_write(2'd0, 8'h06);
    for (int i = 0; i < 20; i++) begin
      do_step(m[5] ^ inv[i]);
      m = mstep(m, 6'h03, 1'b0, 1'b0);
    end
  endtask

  initial begin
    logic [5:0]  m;
    logic [63:0] seen;
    int          dups;

    rst = 1'b1; sel = 1'b0; wr = 1'b0; rd = 1'b0; step = 1'b0; din = 1'b0;
    addr = 2'd0; wdata = 8'h00;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err_cnt), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    bus_read(2'd1, 32'h01, "rst_lfsr");
    bus_read(2'd2, 32'h03, "rst_poly");
    bus_read(2'd0, 32'h00, "rst_ctrl");
    bus_read(2'd3, 32'h00, "rst_cnt");

    // PRBS full period
    bus_write(2'd1, 8'h01);
    bus_write(2'd3, 8'd63);
    bus_write(2'd0, 8'h04);
    check("prbs_busy", 32'(busy), 32'd1);
    m = 6'h01; seen = '0; dups = 0;
    for (int i = 0; i < 63; i++) begin
      do_step(1'b0);
      m = mstep(m, 6'h03, 1'b0, 1'b0);
      check("prbs_dout", 32'(dout), 32'(m[5]));
      bus_read(2'd1, 32'(m), "prbs_lfsr");
      if (seen[rdata[5:0]] || rdata[5:0] == 6'h00) dups++;
      seen[rdata[5:0]] = 1'b1;
    end
    check("prbs_distinct", 32'(dups), 32'd0);
    check("prbs_done", 32'(done), 32'd1);
    bus_read(2'd1, 32'h01, "prbs_final");
    bus_read(2'd3, 32'h00, "prbs_cnt");

    // CRC single bit
    bus_write(2'd1, 8'h00);
    bus_write(2'd3, 8'd1);
    bus_write(2'd0, 8'h05);
    do_step(1'b1);
    check("crc1_done", 32'(done), 32'd1);
    bus_read(2'd1, 32'h03, "crc1_lfsr");
    bus_read(2'd0, 32'h05, "crc1_ctrl");
    bus_write(2'd0, 8'h05);
    do_step(1'b0);
    check("crc0_done", 32'(done), 32'd1);
    bus_read(2'd1, 32'h00, "crc0_lfsr");

    // Check mode: clean, two errors, saturation
    run_check(20'h00000);
    check("chk_clean_done", 32'(done), 32'd1);
    check("chk_clean_err", 32'(err_cnt), 32'd0);
    run_check(20'h01020);
    check("chk_two_err", 32'(err_cnt), 32'd2);
    check("chk_two_err2", 32'(err_cnt2), 32'd2);
    run_check(20'h0001f);
    check("chk_five_err", 32'(err_cnt), 32'd5);
    check("chk_sat_err2", 32'(err_cnt2), 32'd3);
    bus_read(2'd0, 32'h06, "chk_ctrl");

    // Ignored write while busy, then abort beating a step
    bus_write(2'd1, 8'h01);
    bus_write(2'd3, 8'd10);
    bus_write(2'd0, 8'h04);
    m = 6'h01;
    for (int i = 0; i < 4; i++) begin
      do_step(1'b0);
      m = mstep(m, 6'h03, 1'b0, 1'b0);
    end
    bus_write(2'd2, 8'h21);
    bus_read(2'd2, 32'h03, "busy_poly");
    step = 1'b1; sel = 1'b1; wr = 1'b1; addr = 2'd0; wdata = 8'h08;
    tick();
    step = 1'b0; sel = 1'b0; wr = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_dout", 32'(dout), 32'(m[5]));
    bus_read(2'd3, 32'd6, "abort_cnt");
    bus_read(2'd1, 32'(m), "abort_lfsr");
    tick();
    check("rdata_hold", 32'(rdata), 32'(m));
    bus_read(2'd0, 32'h00, "abort_ctrl");

    // Zero length start, idle step ignored
    bus_write(2'd3, 8'd0);
    bus_write(2'd0, 8'h04);
    check("len0_done", 32'(done), 32'd1);
    check("len0_busy", 32'(busy), 32'd0);
    bus_read(2'd3, 32'd0, "len0_cnt");
    do_step(1'b1);
    bus_read(2'd1, 32'h01, "len0_lfsr");

    // Zero seed in PRBS, then reset mid-run
    bus_write(2'd1, 8'h00);
    bus_write(2'd3, 8'd5);
    bus_write(2'd0, 8'h04);
    check("seed0_busy", 32'(busy), 32'd1);
    bus_read(2'd1, 32'h01, "seed0_lfsr");
    do_step(1'b0);
    do_step(1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_rdata", 32'(rdata), 32'd0);
    bus_read(2'd1, 32'h01, "midrst_lfsr");
    bus_read(2'd3, 32'h00, "midrst_cnt");
    bus_read(2'd2, 32'h03, "midrst_poly");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
